// File: rtl/xg_mac_pkg.sv
// Shared AXI-Stream widths, write-side FSM state type and counter helper for the 10G MAC RX path.
package xg_mac_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 64;
    localparam int unsigned AXIS_KEEP_WIDTH = 8;
    localparam int unsigned BUF_WIDTH       = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 1;

    typedef enum logic [0:0] {
        WrPass,
        WrDiscard
    } wr_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/xg_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module xg_sdp_ram #(
    parameter int unsigned WIDTH      = 73,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    logic [WIDTH-1:0] mem_q [1 << ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/xg_rx_frame_filter.sv
// Store-and-forward RX filter: buffers whole frames, drops errored or overflowing ones, and
// forwards committed frames through a 2-entry skid so the output can stream at full rate.
module xg_rx_frame_filter
    import xg_mac_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [AXIS_DATA_WIDTH-1:0] saxis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] saxis_tkeep,
    input  logic                       saxis_tvalid,
    input  logic                       saxis_tlast,
    input  logic                       saxis_tuser,
    output logic [AXIS_DATA_WIDTH-1:0] maxis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] maxis_tkeep,
    output logic                       maxis_tvalid,
    output logic                       maxis_tlast,
    output logic                       maxis_tuser,
    input  logic                       maxis_tready,
    output logic [31:0]                stat_good,
    output logic [31:0]                stat_err_drop,
    output logic [31:0]                stat_ovf_drop
);

    localparam logic [ADDR_WIDTH:0] Depth = {1'b1, {ADDR_WIDTH{1'b0}}};

    wr_state_e             wr_state_q;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_commit_q, rd_ptr_q;
    logic                  full, wr_en, rd_en, pop, rd_vld_q;
    logic [1:0]            skid_cnt_q;
    logic [BUF_WIDTH-1:0]  wr_word, ram_rdata, skid0_q, skid1_q;

    assign full    = (wr_ptr_q - rd_ptr_q) == Depth;
    assign wr_word = {saxis_tlast, saxis_tkeep, saxis_tdata};
    assign wr_en   = saxis_tvalid && (wr_state_q == WrPass) && !full
                     && !(saxis_tlast && saxis_tuser);
    assign pop     = maxis_tvalid && maxis_tready;
    // Reserve a skid slot for every read in flight so returning RAM data always has a home.
    assign rd_en   = (rd_ptr_q != wr_commit_q)
                     && (({1'b0, skid_cnt_q} + {2'b00, rd_vld_q}) <= (3'd1 + {2'b00, pop}));

    assign maxis_tvalid = (skid_cnt_q != 2'd0);
    assign {maxis_tlast, maxis_tkeep, maxis_tdata} = skid0_q;
    assign maxis_tuser  = 1'b0;

    xg_sdp_ram #(
        .WIDTH      (BUF_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clock),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (wr_word),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q    <= WrPass;
            wr_ptr_q      <= '0;
            wr_commit_q   <= '0;
            stat_good     <= '0;
            stat_err_drop <= '0;
            stat_ovf_drop <= '0;
        end else if (saxis_tvalid) begin
            unique case (wr_state_q)
                WrPass: begin
                    // Overflow wins over a bad tuser so each frame bumps exactly one counter.
                    if (full) begin
                        wr_ptr_q <= wr_commit_q;
                        if (saxis_tlast) begin
                            stat_ovf_drop <= sat_inc(stat_ovf_drop);
                        end else begin
                            wr_state_q <= WrDiscard;
                        end
                    end else if (saxis_tlast && saxis_tuser) begin
                        wr_ptr_q      <= wr_commit_q;
                        stat_err_drop <= sat_inc(stat_err_drop);
                    end else begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (saxis_tlast) begin
                            wr_commit_q <= wr_ptr_q + 1'b1;
                            stat_good   <= sat_inc(stat_good);
                        end
                    end
                end
                WrDiscard: begin
                    if (saxis_tlast) begin
                        stat_ovf_drop <= sat_inc(stat_ovf_drop);
                        wr_state_q    <= WrPass;
                    end
                end
                default: wr_state_q <= WrPass;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            rd_vld_q   <= 1'b0;
            skid_cnt_q <= 2'd0;
            skid0_q    <= '0;
        end else begin
            rd_vld_q   <= rd_en;
            skid_cnt_q <= skid_cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (rd_vld_q) begin
                if (skid_cnt_q == 2'd0 || (skid_cnt_q == 2'd1 && pop)) begin
                    skid0_q <= ram_rdata;
                end else if (skid_cnt_q == 2'd2 && pop) begin
                    skid0_q <= skid1_q;
                    skid1_q <= ram_rdata;
                end else begin
                    skid1_q <= ram_rdata;
                end
            end else if (pop && skid_cnt_q == 2'd2) begin
                skid0_q <= skid1_q;
            end
        end
    end

endmodule

// File: tb/tb_xg_rx_frame_filter.sv
// Directed bench for xg_rx_frame_filter: a 16-beat instance for the directed cases and a default
// 512-beat instance, sharing the same stimulus, for the long random-backpressure stream.
module tb_xg_rx_frame_filter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic        m_tready;

    logic [63:0] a_tdata, b_tdata;
    logic [7:0]  a_tkeep, b_tkeep;
    logic        a_tvalid, a_tlast, a_tuser, b_tvalid, b_tlast, b_tuser;
    logic [31:0] a_good, a_err, a_ovf, b_good, b_err, b_ovf;

    int checks = 0, errors = 0, cyc = 0, last_cyc = 0;
    int rdy_mode = 1;
    bit rand_on = 1'b0;
    int sent_beats = 0, recv_beats = 0;
    logic [72:0] cap_q[$];
    int          cap_t[$];
    logic [72:0] exp_q[$];

    xg_rx_frame_filter #(.ADDR_WIDTH(4)) dut_small (
        .clock(clock), .reset(reset),
        .saxis_tdata(s_tdata), .saxis_tkeep(s_tkeep), .saxis_tvalid(s_tvalid),
        .saxis_tlast(s_tlast), .saxis_tuser(s_tuser),
        .maxis_tdata(a_tdata), .maxis_tkeep(a_tkeep), .maxis_tvalid(a_tvalid),
        .maxis_tlast(a_tlast), .maxis_tuser(a_tuser), .maxis_tready(m_tready),
        .stat_good(a_good), .stat_err_drop(a_err), .stat_ovf_drop(a_ovf)
    );

    xg_rx_frame_filter dut_big (
        .clock(clock), .reset(reset),
        .saxis_tdata(s_tdata), .saxis_tkeep(s_tkeep), .saxis_tvalid(s_tvalid),
        .saxis_tlast(s_tlast), .saxis_tuser(s_tuser),
        .maxis_tdata(b_tdata), .maxis_tkeep(b_tkeep), .maxis_tvalid(b_tvalid),
        .maxis_tlast(b_tlast), .maxis_tuser(b_tuser), .maxis_tready(m_tready),
        .stat_good(b_good), .stat_err_drop(b_err), .stat_ovf_drop(b_ovf)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // tready: 0 = low, 1 = high, 2 = coin flip each cycle.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            m_tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        end
    end

    task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [72:0] beat(input int fid, input int nbytes, input int i);
        logic [63:0] d;
        logic [7:0]  k;
        int          nb;
        d  = '0;
        k  = '0;
        nb = (nbytes + 7) / 8;
        for (int b = 0; b < 8; b++) begin
            if (i * 8 + b < nbytes) begin
                d[b*8 +: 8] = 8'(fid * 13 + i * 8 + b);
                k[b]        = 1'b1;
            end
        end
        return {(i == nb - 1), k, d};
    endfunction

    task automatic drive_beat(input logic [72:0] w, input logic user);
        s_tdata  = w[63:0];
        s_tkeep  = w[71:64];
        s_tlast  = w[72];
        s_tuser  = user && w[72];
        s_tvalid = 1'b1;
        @(posedge clock);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic send_frame(input int fid, input int nbytes, input logic user, input bit push);
        int nb;
        nb = (nbytes + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            if (push) begin
                exp_q.push_back(beat(fid, nbytes, i));
                sent_beats++;
            end
            drive_beat(beat(fid, nbytes, i), user);
        end
        last_cyc = cyc;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cap_q.delete();
        cap_t.delete();
    endtask

    task automatic check_frame(input string tag, input int base, input int fid, input int nbytes);
        for (int i = 0; i < (nbytes + 7) / 8; i++) begin
            check(tag, cap_q[base + i], beat(fid, nbytes, i));
        end
    endtask

    always @(negedge clock) begin
        if (!rand_on && a_tvalid && m_tready) begin
            cap_q.push_back({a_tlast, a_tkeep, a_tdata});
            cap_t.push_back(cyc);
        end
    end

    logic        prev_stall = 1'b0;
    logic [72:0] prev_w = '0;
    always @(negedge clock) begin
        if (rand_on) begin
            if (prev_stall) begin
                check("hold_valid", 73'(b_tvalid), 73'd1);
                check("hold_data", {b_tlast, b_tkeep, b_tdata}, prev_w);
            end
            if (b_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL extra_beat: observed %0h expected none", {b_tlast, b_tkeep, b_tdata});
                end else begin
                    check("rand_beat", {b_tlast, b_tkeep, b_tdata}, exp_q.pop_front());
                end
                recv_beats++;
            end
            prev_stall = b_tvalid && !m_tready;
            prev_w     = {b_tlast, b_tkeep, b_tdata};
        end
    end

    initial begin
        int waited;
        int nbytes;
        wait_cycles(2);
        reset = 1'b0;
        check("rst_tvalid", 73'(a_tvalid), 73'd0);
        check("rst_word", {a_tlast, a_tkeep, a_tdata}, 73'd0);
        check("rst_good", 73'(a_good), 73'd0);
        check("rst_err", 73'(a_err), 73'd0);
        check("rst_ovf", 73'(a_ovf), 73'd0);
        check("rst_tuser", 73'(a_tuser), 73'd0);

        // One 64-byte good frame, latency measured from the tlast sampling edge.
        send_frame(1, 64, 1'b0, 1'b0);
        wait_cycles(12);
        check("f64_count", 73'(cap_q.size()), 73'd8);
        check_frame("f64_beat", 0, 1, 64);
        check("f64_latency", 73'(cap_t[0] - last_cyc), 73'd2);
        check("f64_lastkeep", 73'(cap_q[7][71:64]), 73'h0FF);
        check("f64_good", 73'(a_good), 73'd1);

        // Errored 100-byte frame followed by a 60-byte good frame.
        do_reset();
        send_frame(2, 100, 1'b1, 1'b0);
        send_frame(3, 60, 1'b0, 1'b0);
        wait_cycles(12);
        check("err_count", 73'(cap_q.size()), 73'd8);
        check_frame("err_beat", 0, 3, 60);
        check("err_lastkeep", 73'(cap_q[7][71:64]), 73'h00F);
        check("err_errcnt", 73'(a_err), 73'd1);
        check("err_good", 73'(a_good), 73'd1);
        check("err_ovf", 73'(a_ovf), 73'd0);

        // Three frames into a 16-beat buffer with tready low: the third overflows.
        do_reset();
        rdy_mode = 0;
        wait_cycles(2);
        send_frame(4, 64, 1'b0, 1'b0);
        send_frame(5, 64, 1'b0, 1'b0);
        send_frame(6, 64, 1'b0, 1'b0);
        wait_cycles(4);
        check("ovf_ovfcnt", 73'(a_ovf), 73'd1);
        check("ovf_good", 73'(a_good), 73'd2);
        check("ovf_tvalid", 73'(a_tvalid), 73'd1);
        check("ovf_head", {a_tlast, a_tkeep, a_tdata}, beat(4, 64, 0));
        wait_cycles(3);
        check("ovf_hold", {a_tlast, a_tkeep, a_tdata}, beat(4, 64, 0));
        rdy_mode = 1;
        wait_cycles(30);
        check("ovf_count", 73'(cap_q.size()), 73'd16);
        check_frame("ovf_f1", 0, 4, 64);
        check_frame("ovf_f2", 8, 5, 64);

        // Buffer fills exactly on a tlast beat: dropped frame, write FSM stays ready.
        do_reset();
        rdy_mode = 0;
        wait_cycles(2);
        send_frame(7, 64, 1'b0, 1'b0);
        send_frame(8, 88, 1'b0, 1'b0);
        wait_cycles(4);
        check("lastfull_ovf", 73'(a_ovf), 73'd1);
        check("lastfull_good", 73'(a_good), 73'd1);
        rdy_mode = 1;
        wait_cycles(20);
        send_frame(9, 64, 1'b0, 1'b0);
        wait_cycles(14);
        check("lastfull_count", 73'(cap_q.size()), 73'd16);
        check_frame("lastfull_f9", 8, 9, 64);
        check("lastfull_good2", 73'(a_good), 73'd2);

        // Reset mid-frame with one committed frame still pending.
        do_reset();
        rdy_mode = 0;
        wait_cycles(2);
        send_frame(10, 64, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_beat(beat(11, 64, i), 1'b0);
        end
        check("midrst_pre_good", 73'(a_good), 73'd1);
        do_reset();
        check("midrst_tvalid", 73'(a_tvalid), 73'd0);
        check("midrst_good", 73'(a_good), 73'd0);
        check("midrst_ovf", 73'(a_ovf), 73'd0);
        rdy_mode = 1;
        wait_cycles(2);
        cap_q.delete();
        cap_t.delete();
        send_frame(12, 64, 1'b0, 1'b0);
        wait_cycles(12);
        check("midrst_count", 73'(cap_q.size()), 73'd8);
        check_frame("midrst_beat", 0, 12, 64);
        check("midrst_good2", 73'(a_good), 73'd1);

        // 100 good frames of random length through the 512-beat instance, random tready.
        do_reset();
        sent_beats = 0;
        recv_beats = 0;
        rdy_mode   = 2;
        rand_on    = 1'b1;
        for (int f = 0; f < 100; f++) begin
            nbytes = $urandom_range(60, 1500);
            waited = 0;
            while ((sent_beats - recv_beats + (nbytes + 7) / 8 > 500) && waited < 4000) begin
                wait_cycles(1);
                waited++;
            end
            if (waited >= 4000) begin
                checks++;
                errors++;
                $error("FAIL pace_timeout: observed %0d outstanding beats expected <= 500",
                       sent_beats - recv_beats);
                break;
            end
            send_frame(int'($urandom_range(0, 255)), nbytes, 1'b0, 1'b1);
        end
        waited = 0;
        while (exp_q.size() != 0 && waited < 40000) begin
            wait_cycles(1);
            waited++;
        end
        check("rand_drained", 73'(exp_q.size()), 73'd0);
        check("rand_good", 73'(b_good), 73'd100);
        check("rand_err", 73'(b_err), 73'd0);
        check("rand_ovf", 73'(b_ovf), 73'd0);
        rand_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xg_rx_frame_filter.md
XG_RX_FRAME_FILTER -- requirements
Module: xg_rx_frame_filter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 9, log2 of buffer depth in 64-bit beats (512 beats; one 1500-byte frame needs 188 beats).
REQ-002 clock  input  1  single clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 saxis_tdata  input  64  received data from xg_mac_rx, byte 0 in bits [7:0].
REQ-005 saxis_tvalid/saxis_tkeep/saxis_tlast/saxis_tuser  input  1/8/1/1  beat valid, byte enables, end of frame, error flag (meaningful on tlast beat only; 1 = bad frame).
REQ-006 No saxis_tready: input is never back-pressured.
REQ-007 maxis_tdata/maxis_tkeep/maxis_tlast  output  64/8/1  forwarded good-frame beats.
REQ-008 maxis_tvalid  output  1; maxis_tready  input  1; maxis_tuser  output  1, constant 0.
REQ-009 stat_good, stat_err_drop, stat_ovf_drop  output  32 each  saturating frame counters.

Function
REQ-010 Store-and-forward: no beat of a frame appears on maxis before its tlast beat has been written and the frame committed.
REQ-011 Buffer word = {tlast, tkeep, tdata} (73 bits); pointers wr_ptr, wr_commit, rd_ptr are ADDR_WIDTH+1 bits, wrapping modulo 2^(ADDR_WIDTH+1).
REQ-012 Full = (wr_ptr - rd_ptr) == 2^ADDR_WIDTH; empty-for-read = (rd_ptr == wr_commit).
REQ-013 Write FSM states WR_PASS, WR_DISCARD; reset state WR_PASS.
REQ-014 WR_PASS, valid beat, not full: write at wr_ptr, wr_ptr+1.
REQ-015 WR_PASS, valid tlast beat, tuser=0, not full: write, wr_commit <= wr_ptr+1, stat_good+1.
REQ-016 WR_PASS, valid tlast beat, tuser=1: no write, wr_ptr <= wr_commit, stat_err_drop+1.
REQ-017 WR_PASS, valid non-last beat while full: no write, wr_ptr <= wr_commit, go WR_DISCARD.
REQ-018 WR_PASS, valid tlast beat while full: no write, wr_ptr <= wr_commit, stat_ovf_drop+1, stay WR_PASS.
REQ-019 WR_DISCARD: drop all beats; on valid tlast beat: stat_ovf_drop+1 (regardless of tuser), go WR_PASS.
REQ-020 Overflow and error on the same frame count as overflow only; each frame increments exactly one counter.
REQ-021 Read side: synchronous RAM read (1-cycle latency) feeding a 2-entry output skid so maxis sustains one beat per cycle while tready=1.
REQ-022 AXIS rule: once maxis_tvalid=1, tdata/tkeep/tlast hold until maxis_tready=1.
REQ-023 Latency: with maxis_tready=1 and empty buffer, first beat of a frame is valid on maxis 2 cycles after its tlast beat is sampled.
REQ-024 rd_ptr advances on RAM read issue; space is freed at issue, not at maxis handshake; skid never overflows.
REQ-025 Simultaneous write and read at same cycle permitted; RAM read returns old-or-new data irrelevant because reads stay below wr_commit.
REQ-026 Counters saturate at 0xFFFF_FFFF.

Reset
REQ-027 On reset: all pointers 0, FSM WR_PASS, skid empty, maxis_tvalid=0, maxis_tdata/tkeep/tlast=0, all stat counters 0.
REQ-028 Reset mid-frame: partial and committed-but-unsent frames are discarded; first valid beat after reset release starts a new frame.
REQ-029 RAM contents are not reset.

Structure
REQ-030 Shared package xg_mac_pkg holds AXIS_DATA_WIDTH=64, AXIS_KEEP_WIDTH=8 and the write-FSM enum type.
REQ-031 Buffer storage in one sub-module xg_sdp_ram (simple dual-port, registered read, parameterised width/depth).

Verification
REQ-032 One 64-byte good frame (8 beats, tkeep last=FF), tready=1 -> identical 8 beats out, first beat 2 cycles after tlast, stat_good=1.
REQ-033 Frame of 100 bytes with tuser=1 on tlast, then 60-byte good frame -> only the 60-byte frame output (last tkeep=0F), stat_err_drop=1, stat_good=1.
REQ-034 tready=0, ADDR_WIDTH=4, three 64-byte frames -> first two stored, third dropped, stat_ovf_drop=1; release tready -> exactly 16 beats out.
REQ-035 Random tready (50%), 100 frames 60..1500 bytes, good only -> output byte stream equals input, no tvalid drop before handshake.
REQ-036 reset asserted for 1 cycle mid-frame with one committed frame pending -> maxis_tvalid=0 next cycle, counters 0, subsequent good frame passes intact.
